// File: rtl/debounce_multi_if.sv
// Button-side bundle for debounce_multi: raw button levels in, clean key levels and strobes out.
// The debouncer takes the slave modport and the button source or bench takes the master modport.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic            tick;
  logic [N_CH-1:0] key;
  logic [N_CH-1:0] key_press;
  logic [N_CH-1:0] key_release;
  logic [N_CH-1:0] key_long;

  modport master (
    output btn_in,
    input  tick,
    input  key,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  btn_in,
    output tick,
    output key,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: one tick prescaler shared by every channel, plus per-channel
// synchroniser, stability counter and long-press counter driving registered single-cycle strobes.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int CLK_DIV      = 50000,
  parameter int STABLE_TICKS = 30,
  parameter int LONG_TICKS   = 1000,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk,
  input  logic rst,
  debounce_multi_if.slave bus
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [N_CH-1:0] IDLE = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [PW-1:0]   pcnt;
  logic            tick_r;
  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] key_r;
  logic [N_CH-1:0] press_r;
  logic [N_CH-1:0] release_r;
  logic [N_CH-1:0] long_r;
  logic [SW-1:0]   scnt [N_CH];
  logic [LW-1:0]   lcnt [N_CH];

  // tick is registered one count early so it is high exactly while pcnt == CLK_DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt   <= '0;
      tick_r <= 1'b0;
    end else begin
      if (pcnt == PW'(CLK_DIV - 1)) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
      tick_r <= (pcnt == PW'(CLK_DIV - 2));
    end
  end

  // Synchroniser resets to the idle level so an idle button produces no event at reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      s     <= '0;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
      s     <= sync2 ^ IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_r     <= '0;
      press_r   <= '0;
      release_r <= '0;
      long_r    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        scnt[i] <= '0;
        lcnt[i] <= '0;
      end
    end else begin
      press_r   <= '0;
      release_r <= '0;
      long_r    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (tick_r) begin
          if (s[i] == key_r[i]) begin
            scnt[i] <= '0;
          end else if (scnt[i] == SW'(STABLE_TICKS - 1)) begin
            key_r[i]     <= s[i];
            scnt[i]      <= '0;
            press_r[i]   <= s[i];
            release_r[i] <= ~s[i];
          end else begin
            scnt[i] <= scnt[i] + SW'(1);
          end
        end

        // Saturating at LONG_TICKS makes key_long a one-shot per press
        if (!key_r[i]) begin
          lcnt[i] <= '0;
        end else if (tick_r && (lcnt[i] < LW'(LONG_TICKS))) begin
          lcnt[i] <= lcnt[i] + LW'(1);
          if (lcnt[i] == LW'(LONG_TICKS - 1)) begin
            long_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.tick        = tick_r;
  assign bus.key         = key_r;
  assign bus.key_press   = press_r;
  assign bus.key_release = release_r;
  assign bus.key_long    = long_r;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: a table of tick-aligned button segments with expected key level and
// strobe counts, checked through a scoreboard queue, plus reset and active-low sequences.
module tb_debounce_multi;

  localparam int N_CH         = 2;
  localparam int CLK_DIV      = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 8;

  typedef struct {
    logic [1:0] btn;
    int         ticks;
    logic [1:0] key;
    int         p0;
    int         p1;
    int         r0;
    int         r1;
    int         l0;
    int         l1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debounce_multi_if #(.N_CH(N_CH)) bus ();
  debounce_multi_if #(.N_CH(N_CH)) bus_al ();

  debounce_multi #(
    .N_CH(N_CH), .CLK_DIV(CLK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS(LONG_TICKS), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  debounce_multi #(
    .N_CH(N_CH), .CLK_DIV(CLK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS(LONG_TICKS), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .bus(bus_al)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t sb[$];

  int tot_p [2];
  int tot_r [2];
  int tot_l [2];
  int viol = 0;
  int cyc = 0;
  int last_p0 = -1;
  int last_r1 = -2;
  int al_press0 = 0;
  int al_strobes = 0;
  logic [1:0] prev_key = 2'b00;

  int snap_p [2];
  int snap_r [2];
  int snap_l [2];
  int snap_viol;

  // Strobe monitor: counts high cycles and flags strobes that disagree with the key edge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst === 1'b1) begin
      if ((bus.key_press !== (bus.key & ~prev_key)) ||
          (bus.key_release !== (~bus.key & prev_key)))
        viol++;
    end
    prev_key = bus.key;
    for (int i = 0; i < 2; i++) begin
      if (bus.key_press[i] === 1'b1)   tot_p[i]++;
      if (bus.key_release[i] === 1'b1) tot_r[i]++;
      if (bus.key_long[i] === 1'b1)    tot_l[i]++;
    end
    if (bus.key_press[0] === 1'b1)   last_p0 = cyc;
    if (bus.key_release[1] === 1'b1) last_r1 = cyc;
    if (bus_al.key_press[0] === 1'b1) al_press0++;
    al_strobes += $countones({bus_al.key_press, bus_al.key_release, bus_al.key_long});
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, ".tick"},    32'(bus.tick), 0);
    check_val({tag, ".key"},     32'(bus.key), 0);
    check_val({tag, ".press"},   32'(bus.key_press), 0);
    check_val({tag, ".release"}, 32'(bus.key_release), 0);
    check_val({tag, ".long"},    32'(bus.key_long), 0);
  endtask

  // Ends at the negedge one cycle after the n-th tick, when that tick's results are visible
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.tick !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (bus.tick !== 1'b1) begin
        checks++;
        errors++;
        $display("[TB] FAIL tick_timeout: got no tick expected one within 20 clk");
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic void add_vec(input logic [1:0] btn, input int ticks, input logic [1:0] key,
                                  input int p0, input int p1, input int r0, input int r1,
                                  input int l0, input int l1);
    vec_t v;
    v.btn = btn; v.ticks = ticks; v.key = key;
    v.p0 = p0; v.p1 = p1; v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.btn_in = v.btn;
    for (int i = 0; i < 2; i++) begin
      snap_p[i] = tot_p[i];
      snap_r[i] = tot_r[i];
      snap_l[i] = tot_l[i];
    end
    snap_viol = viol;
    sb.push_back(v);
    wait_ticks(v.ticks);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check_val({tag, ".key"},  32'(bus.key), 32'(e.key));
    check_val({tag, ".p0"},   32'(tot_p[0] - snap_p[0]), 32'(e.p0));
    check_val({tag, ".p1"},   32'(tot_p[1] - snap_p[1]), 32'(e.p1));
    check_val({tag, ".r0"},   32'(tot_r[0] - snap_r[0]), 32'(e.r0));
    check_val({tag, ".r1"},   32'(tot_r[1] - snap_r[1]), 32'(e.r1));
    check_val({tag, ".l0"},   32'(tot_l[0] - snap_l[0]), 32'(e.l0));
    check_val({tag, ".l1"},   32'(tot_l[1] - snap_l[1]), 32'(e.l1));
    check_val({tag, ".edge"}, 32'(viol - snap_viol), 0);
    if (e.p0 == 1 && e.r1 == 1)
      check_val({tag, ".same_cycle"}, 32'(last_r1), 32'(last_p0));
  endtask

  initial begin
    int n;
    int al_base;
    vec_t v;

    rst = 1'b0;
    bus.btn_in = 2'b00;
    bus_al.btn_in = 2'b11;

    // btn, ticks, key, p0 p1 r0 r1 l0 l1
    add_vec(2'b00, 4, 2'b00, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 2, 2'b00, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1, 2'b01, 1, 0, 0, 0, 0, 0);
    add_vec(2'b01, 7, 2'b01, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1, 2'b01, 0, 0, 0, 0, 1, 0);
    add_vec(2'b01, 7, 2'b01, 0, 0, 0, 0, 0, 0);
    add_vec(2'b00, 2, 2'b01, 0, 0, 0, 0, 0, 0);
    add_vec(2'b00, 1, 2'b00, 0, 0, 1, 0, 0, 0);
    for (int b = 0; b < 6; b++)
      add_vec((b % 2 == 0) ? 2'b01 : 2'b00, 2, 2'b00, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 2, 2'b00, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1, 2'b01, 1, 0, 0, 0, 0, 0);
    add_vec(2'b01, 7, 2'b01, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1, 2'b01, 0, 0, 0, 0, 1, 0);
    add_vec(2'b11, 2, 2'b01, 0, 0, 0, 0, 0, 0);
    add_vec(2'b11, 1, 2'b11, 0, 1, 0, 0, 0, 0);
    add_vec(2'b10, 3, 2'b10, 0, 0, 1, 0, 0, 0);
    add_vec(2'b01, 2, 2'b10, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, 1, 2'b01, 1, 0, 0, 1, 0, 0);
    add_vec(2'b00, 3, 2'b00, 0, 0, 1, 0, 0, 0);
    add_vec(2'b10, 3, 2'b10, 0, 1, 0, 0, 0, 0);
    add_vec(2'b11, 2, 2'b10, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.tick !== 1'b1 && n < 10);
    check_val("first_tick", 32'(n), 32'(CLK_DIV - 1));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.tick !== 1'b1 && n < 10);
    check_val("tick_period", 32'(n), 32'(CLK_DIV));
    @(posedge clk); #1;
    check_val("tick_width", 32'(bus.tick), 0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i));
    end

    // Reset while ch0 is two ticks into its window and ch1 is pressed
    rst = 1'b0;
    #1;
    check_reset("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    v = '{btn: 2'b11, ticks: 2, key: 2'b00, p0: 0, p1: 0, r0: 0, r1: 0, l0: 0, l1: 0};
    applyStimulus(v);
    checkOutput("post_reset_wait");
    v = '{btn: 2'b11, ticks: 1, key: 2'b11, p0: 1, p1: 1, r0: 0, r1: 0, l0: 0, l1: 0};
    applyStimulus(v);
    checkOutput("post_reset_press");

    check_val("al.idle_key", 32'(bus_al.key), 0);
    check_val("al.idle_strobes", 32'(al_strobes), 0);
    al_base = al_press0;
    bus_al.btn_in = 2'b10;
    wait_ticks(2);
    check_val("al.wait_key", 32'(bus_al.key), 0);
    wait_ticks(1);
    check_val("al.key", 32'(bus_al.key), 1);
    check_val("al.press", 32'(al_press0 - al_base), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
